// File: rtl/seq_pattern_detector.sv
// Runtime-programmable sliding-window sequence detector for SYM_W-bit symbols.
module seq_pattern_detector #(
  parameter int SYM_W   = 2,
  parameter int MAX_LEN = 12,
  parameter int IDX_W   = 4,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [SYM_W-1:0] cfg_sym,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             overlap,
  input  logic             sample_valid,
  input  logic [SYM_W-1:0] sample,
  output logic             match,
  output logic [LEN_W-1:0] fill,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             flush
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, HUNT} state_t;

  state_t           state_q, state_d;
  logic [SYM_W-1:0] pat_q  [MAX_LEN];
  logic [SYM_W-1:0] pat_d  [MAX_LEN];
  logic [SYM_W-1:0] hist_q [MAX_LEN];
  logic [SYM_W-1:0] hist_d [MAX_LEN];
  logic [SYM_W-1:0] hist_sh[MAX_LEN];
  logic [LEN_W-1:0] fill_q, fill_d, fill_nx;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [TO_W-1:0]  idle_q, idle_d;
  logic             match_q, match_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eq;
  logic [IDX_W-1:0] pidx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '{default: '0};
      hist_q  <= '{default: '0};
      fill_q  <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      idle_q  <= '0;
      match_q <= 1'b0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      idle_q  <= idle_d;
      match_q <= match_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    idle_d  = idle_q;
    match_d = 1'b0;
    flush_d = 1'b0;
    cnt_d   = cnt_q;
    pidx    = '0;

    // Window compare always runs on the post-shift history; it is only acted on for a valid sample.
    hist_sh[0] = sample;
    for (int unsigned k = 1; k < MAX_LEN; k++) begin
      hist_sh[k] = hist_q[k-1];
    end
    fill_nx = (fill_q < len_q) ? fill_q + 1'b1 : len_q;
    eq = (len_q != '0);
    for (int unsigned k = 0; k < MAX_LEN; k++) begin
      if (k < 32'(len_q)) begin
        pidx = IDX_W'(32'(len_q) - 1 - k);
        if (hist_sh[k] != pat_q[pidx]) begin
          eq = 1'b0;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (cfg_we && (int'(cfg_idx) < MAX_LEN)) begin
          pat_d[cfg_idx] = cfg_sym;
        end
        if (enable) begin
          state_d = HUNT;
          len_d   = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
          ovl_d   = overlap;
          idle_d  = '0;
        end
      end
      HUNT: begin
        if (!enable) begin
          state_d = IDLE;
          hist_d  = '{default: '0};
          fill_d  = '0;
          idle_d  = '0;
        end else if (sample_valid) begin
          hist_d = hist_sh;
          idle_d = '0;
          if (eq && (fill_nx == len_q)) begin
            match_d = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
            fill_d = ovl_q ? len_q : '0;
          end else begin
            fill_d = fill_nx;
          end
        end else if (TIMEOUT > 0) begin
          // Counter stops at TIMEOUT so the flush fires once per idle stretch.
          if (idle_q < TO_W'(TIMEOUT)) begin
            idle_d = idle_q + 1'b1;
            if ((idle_d == TO_W'(TIMEOUT)) && (fill_q != '0)) begin
              fill_d  = '0;
              flush_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign match       = match_q;
  assign fill        = fill_q;
  assign match_count = cnt_q;
  assign busy        = (state_q == HUNT);
  assign flush       = flush_q;

endmodule
